// File: rtl/trace_fifo.sv
// Execution-trace capture FIFO: samples core PC/ALU pairs each enabled cycle and drains them over valid/ready.
// Optional TRACE_FILTER_EN suppresses consecutive captures of an unchanged PC.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [WIDTH-1:0]         alu_in,
    input  logic                     capture_en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_alu,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_pc  [DEPTH];
    logic [WIDTH-1:0] mem_alu [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             push_req;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

`ifdef TRACE_FILTER_EN
    logic [WIDTH-1:0] last_pc;
    logic             last_vld;

    // Tracks the last enabled PC even when that sample was dropped on overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
        end else if (clear) begin
            last_pc  <= '0;
            last_vld <= 1'b0;
        end else if (capture_en) begin
            last_pc  <= pc_in;
            last_vld <= 1'b1;
        end
    end

    assign push_req = capture_en && (!last_vld || (pc_in != last_pc));
`else
    assign push_req = capture_en;
`endif

    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !clear;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push_req && !clear && (!full || pop);
    assign drop      = push_req && !clear && full && !pop;

    assign out_pc  = mem_pc[rp];
    assign out_alu = mem_alu[rp];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_pc[wp]  <= pc_in;
            mem_alu[wp] <= alu_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + PTR_ONE;
            end
            if (pop) begin
                rp <= rp + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push_ok) begin
                count <= count - CNT_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/trace_fifo.md
# trace_fifo

Execution-trace capture buffer sitting directly downstream of the single-cycle core top. Each cycle it samples the core's `pc_debug`/`alu_debug` outputs into a circular FIFO. It then drains the stored (PC, ALU result) pairs over a valid/ready stream to a debug sink (UART formatter, logic-analyser port). Overflow is counted rather than back-pressured, because the core cannot stall.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `WIDTH`, 32: width of each captured field.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `pc_in`  in  WIDTH  PC sample (from core `pc_debug`).
- `alu_in`  in  WIDTH  ALU result sample (from core `alu_debug`).
- `capture_en`  in  1  sample `pc_in`/`alu_in` this cycle.
- `clear`  in  1  synchronous flush of FIFO and statistics.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  sink accepts head entry.
- `out_pc`  out  WIDTH  head entry PC.
- `out_alu`  out  WIDTH  head entry ALU result.
- `count`  out  $clog2(DEPTH)+1  entries currently stored (0..DEPTH).
- `overflow`  out  1  sticky: at least one sample was dropped.
- `drop_cnt`  out  16  dropped-sample counter, saturating.

## Operation
- Storage: DEPTH-entry array of {pc, alu}, with write pointer `wp`, read pointer `rp` (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and occupancy `count`.
- Push request: `capture_en`=1 (further qualified by the filter when configured).
- Pop: `out_valid && out_ready`.
- Full = (`count`==DEPTH). Empty = (`count`==0).
- Push when not full: write {pc_in, alu_in} at `wp`, then increment `wp`.
- Push when full with a simultaneous pop: accepted. Write at `wp`, advance both pointers, `count` unchanged.
- Push when full without a pop: sample dropped. Set `overflow` to 1. Increment `drop_cnt`, saturating at 16'hFFFF. Pointers and `count` unchanged.
- Pop when empty: impossible, because `out_valid`=0.
- Push and pop together when empty: the entry is written, and `count` goes 0→1. There is no same-cycle bypass, so `out_valid` rises the next cycle.
- `out_valid` = (`count`!=0). `out_pc`/`out_alu` = array[`rp`], combinational from storage. Their value is don't-care when `out_valid`=0.
- `out_pc`/`out_alu` must hold stable while `out_valid`=1 and `out_ready`=0.
- `clear`=1 has priority over push and pop. It zeroes `wp`, `rp`, `count`, `overflow` and `drop_cnt`, and the sample presented that cycle is discarded.
- Array contents are not reset.

## Timing
- Reset (`reset`=0, asynchronous): `wp`=`rp`=0, `count`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0. `out_pc`/`out_alu` read array[0] (undefined).
- Asserting `reset` mid-operation discards all entries immediately. Operation resumes at the first rising edge after `reset` returns to 1.
- Capture latency: a sample taken at edge N is visible at the head (if the FIFO was empty) with `out_valid`=1 after edge N.
- Pop takes effect at the edge where `out_valid && out_ready`. The next entry appears after that edge.
- Sustained throughput: one push and one pop per cycle.
- `count`, `overflow` and `drop_cnt` are registered and update on the same edge as the causing event.

## Configuration
- Macro `TRACE_FILTER_EN`.
- Defined:
  - A register `last_pc` and flag `last_vld` are added; both are cleared by reset and by `clear`.
  - Push request = `capture_en && (!last_vld || pc_in != last_pc)`.
  - Whenever `capture_en`=1 (and `clear`=0), `last_pc`←`pc_in` and `last_vld`←1. This happens even if the sample is dropped on overflow.
  - Effect: repeated PCs (reset hold, self-loops) are captured once.
- Undefined: push request = `capture_en`, so every enabled cycle is captured. No `last_pc` logic is present.

## Test plan
1. Release reset, `capture_en`=1 for 4 cycles with pc 0,4,8,12 and alu 0x10..0x13, `out_ready`=0 → `count`=4. Head is pc=0, alu=0x10 and holds stable; `overflow`=0.
2. DEPTH=16: push 20 samples with `out_ready`=0 → `count`=16, `overflow`=1, `drop_cnt`=4. Draining returns the first 16 samples in order.
3. FIFO full, `capture_en`=1 and `out_ready`=1 for 8 cycles → no drops, `count` stays 16, output sequence continues without gaps. Pointers wrap past DEPTH-1 correctly.
4. Set `overflow`, then pulse `clear` together with `capture_en` → next cycle `count`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0. The cleared-cycle sample is absent.
5. Assert `reset`=0 asynchronously between edges with `count`=5 → `out_valid` and `count` go to 0 without a clock edge. After release, a push of pc=0x40 appears as the head.
6. With `TRACE_FILTER_EN`: pc sequence 0,0,0,4,4,8 with `capture_en`=1 → exactly 3 entries: 0, 4, 8.
